// File: rtl/onehot_enc_pkg.sv
// rtl/onehot_enc_pkg.sv - shared state encoding for the sequential one-hot encoder
package onehot_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } enc_state_e;

endpackage

// File: rtl/prio_enc_lsb.sv
// rtl/prio_enc_lsb.sv - combinational lowest-set-bit priority encoder
module prio_enc_lsb #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] in,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         single
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in[i]) idx = W'(i);
    end
  end

  assign any    = |in;
  assign single = any && ((in & (in - N'(1))) == '0);

endmodule

// File: rtl/onehot_seq_encoder.sv
// rtl/onehot_seq_encoder.sv - drains a multi-hot request vector as one index per cycle
module onehot_seq_encoder
  import onehot_enc_pkg::*;
#(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         req_valid,
  output logic         in_ready,
  output logic [W-1:0] code,
  output logic         code_valid,
  input  logic         code_ready,
  output logic         code_last,
  output logic         zero_pulse
);

  enc_state_e   state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         zero_pulse_q, zero_pulse_d;
  logic [W-1:0] enc_idx;
  logic         enc_any;
  logic         enc_single;
  logic [N-1:0] clear_mask;
  logic         accept;

  prio_enc_lsb #(.N(N)) u_prio_enc (
    .in     (pending_q),
    .idx    (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

  assign clear_mask = N'(1) << enc_idx;
  assign accept     = code_valid && code_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      zero_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      zero_pulse_q <= zero_pulse_d;
    end
  end

  // Loads only happen from IDLE, so the final accept always leaves one bubble cycle.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    zero_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req != '0) begin
            pending_d = req;
            state_d   = SCAN;
          end else begin
            zero_pulse_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (accept) begin
          pending_d = pending_q & ~clear_mask;
          if (enc_single) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs derive from registered state only, so back-pressure holds them stable.
  always_comb begin
    in_ready   = (state_q == IDLE);
    code_valid = (state_q == SCAN) && enc_any;
    code       = code_valid ? enc_idx : '0;
    code_last  = code_valid && enc_single;
    zero_pulse = zero_pulse_q;
  end

endmodule
